// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field constants, canonical NaN and adder FSM states
package fp32_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALIGN,
      S_ADDNORM,
      S_DONE
   } state_t;

endpackage

// File: rtl/lzc27.sv
// rtl/lzc27.sv - leading-zero counter for the 27-bit extended significand
module lzc27 (
   input  logic [26:0] din,
   output logic [4:0]  count
);

   // Highest set bit wins; an all-zero input reports 27.
   always_comb begin
      count = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (din[i]) count = 5'(26 - i);
      end
   end

endmodule

// File: rtl/addition_stage32.sv
// rtl/addition_stage32.sv - multi-cycle binary32 adder/subtractor stage
module addition_stage32
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic        PlusOrMinus,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cin,
   output logic [31:0] sumFinal,
   output logic        cout,
   output logic        ready
);

   localparam logic [7:0] EXP_ALL1 = 8'(EXP_MAX);

   state_t      state_q, state_d;
   logic [31:0] a_q, b_q;
   logic        pm_q, cin_q;

   // alignment stage combinational values
   logic        sa, sb, nan_a, nan_b, inf_a, inf_b, swap;
   logic [7:0]  ea, eb, ex_c, ey_c, d_c;
   logic [22:0] ma, mb;
   logic [26:0] sigx_c, sigy_c, shr_c, sigy_al;
   logic        sx_c, sticky_c, special_c;
   logic [31:0] special_val_c;

   // alignment stage registers
   logic        sx_q, sub_q, special_q;
   logic [7:0]  ex_q;
   logic [26:0] sigx_q, sigy_q;
   logic [31:0] special_val_q;

   // add / normalize / round combinational values
   logic [27:0]       sum_c;
   logic [26:0]       norm_c;
   logic [4:0]        lz;
   logic signed [9:0] exp_n, exp_r;
   logic              carry_c, round_up;
   logic [24:0]       rnd;
   logic [22:0]       frac_c;
   logic [31:0]       res_c;
   logic              cout_c;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)     state_q <= S_IDLE;
      else if (en) state_q <= state_d;
   end

   // FSM next state: load always restarts from IDLE
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_ALIGN;
            S_ALIGN:   state_d = S_ADDNORM;
            S_ADDNORM: state_d = S_DONE;
            default:   state_d = S_DONE;
         endcase
      end
   end

   // Operand capture while load is held
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0; b_q <= '0; pm_q <= 1'b0; cin_q <= 1'b0;
      end else if (en && load) begin
         a_q <= A; b_q <= B; pm_q <= PlusOrMinus; cin_q <= cin;
      end
   end

   // Unpack, order by magnitude, shift the smaller significand, detect specials
   always_comb begin
      sa    = a_q[31];
      sb    = b_q[31] ^ pm_q;
      ea    = a_q[30:23];
      eb    = b_q[30:23];
      nan_a = (ea == EXP_ALL1) && (a_q[22:0] != '0);
      nan_b = (eb == EXP_ALL1) && (b_q[22:0] != '0);
      inf_a = (ea == EXP_ALL1) && (a_q[22:0] == '0);
      inf_b = (eb == EXP_ALL1) && (b_q[22:0] == '0);
      // exponent 0 is zero: subnormal fractions are discarded
      ma    = (ea == 8'd0) ? 23'd0 : a_q[22:0];
      mb    = (eb == 8'd0) ? 23'd0 : b_q[22:0];
      swap  = {eb, mb} > {ea, ma};
      if (swap) begin
         sx_c   = sb;
         ex_c   = eb;
         ey_c   = ea;
         sigx_c = {(eb != 8'd0), mb, 3'b000};
         sigy_c = {(ea != 8'd0), ma, 3'b000};
      end else begin
         sx_c   = sa;
         ex_c   = ea;
         ey_c   = eb;
         sigx_c = {(ea != 8'd0), ma, 3'b000};
         sigy_c = {(eb != 8'd0), mb, 3'b000};
      end
      d_c      = ex_c - ey_c;
      // shifts past the width give zero, leaving only the sticky bit
      shr_c    = sigy_c >> d_c;
      sticky_c = (shr_c << d_c) != sigy_c;
      sigy_al  = {shr_c[26:1], shr_c[0] | sticky_c};

      special_c     = 1'b1;
      special_val_c = QNAN;
      if (nan_a || nan_b)                 special_val_c = QNAN;
      else if (inf_a && inf_b && sa != sb) special_val_c = QNAN;
      else if (inf_a)                      special_val_c = {sa, EXP_ALL1, 23'd0};
      else if (inf_b)                      special_val_c = {sb, EXP_ALL1, 23'd0};
      else                                 special_c     = 1'b0;
   end

   // Alignment registers, loaded on the IDLE -> ALIGN step
   always_ff @(posedge clk) begin
      if (rst) begin
         sx_q <= 1'b0; sub_q <= 1'b0; special_q <= 1'b0; ex_q <= '0;
         sigx_q <= '0; sigy_q <= '0; special_val_q <= '0;
      end else if (en && !load && state_q == S_IDLE) begin
         sx_q          <= sx_c;
         sub_q         <= sa ^ sb;
         special_q     <= special_c;
         ex_q          <= ex_c;
         sigx_q        <= sigx_c;
         sigy_q        <= sigy_al;
         special_val_q <= special_val_c;
      end
   end

   lzc27 u_lzc (
      .din   (sum_c[26:0]),
      .count (lz)
   );

   // Add/subtract, normalize, round to nearest even, pack
   always_comb begin
      if (sub_q) sum_c = {1'b0, sigx_q} - {1'b0, sigy_q};
      else       sum_c = {1'b0, sigx_q} + {1'b0, sigy_q} + {27'd0, cin_q};
      carry_c = sum_c[27];
      if (carry_c) begin
         norm_c = {sum_c[27:2], sum_c[1] | sum_c[0]};
         exp_n  = {2'b00, ex_q} + 10'sd1;
      end else begin
         norm_c = sum_c[26:0] << lz;
         exp_n  = {2'b00, ex_q} - {5'd0, lz};
      end
      round_up = norm_c[2] & (norm_c[1] | norm_c[0] | norm_c[3]);
      rnd      = {1'b0, norm_c[26:3]} + {24'd0, round_up};
      if (rnd[24]) begin
         frac_c = rnd[23:1];
         exp_r  = exp_n + 10'sd1;
      end else begin
         frac_c = rnd[22:0];
         exp_r  = exp_n;
      end

      res_c  = {sx_q, exp_r[7:0], frac_c};
      cout_c = carry_c;
      if (special_q) begin
         res_c  = special_val_q;
         cout_c = 1'b0;
      end else if (sum_c == 28'd0 || exp_r <= 10'sd0) begin
         res_c  = 32'd0;
         cout_c = 1'b0;
      end else if (exp_r >= 10'sd255) begin
         res_c  = {sx_q, EXP_ALL1, 23'd0};
      end
   end

   // Output registers: result on ALIGN -> ADDNORM, ready one step later
   always_ff @(posedge clk) begin
      if (rst) begin
         sumFinal <= '0;
         cout     <= 1'b0;
         ready    <= 1'b0;
      end else if (en) begin
         if (load) begin
            ready <= 1'b0;
         end else if (state_q == S_ALIGN) begin
            sumFinal <= res_c;
            cout     <= cout_c;
         end else if (state_q == S_ADDNORM) begin
            ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_addition_stage32.sv
// tb/tb_addition_stage32.sv - scoreboard bench for addition_stage32
module tb_addition_stage32;

   logic        clk = 1'b0;
   logic        rst, en, load, PlusOrMinus, cin;
   logic [31:0] A, B;
   logic [31:0] sumFinal;
   logic        cout, ready;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        chk_cout;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic ready_d = 1'b0;

   addition_stage32 dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .load        (load),
      .PlusOrMinus (PlusOrMinus),
      .A           (A),
      .B           (B),
      .cin         (cin),
      .sumFinal    (sumFinal),
      .cout        (cout),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: each rising edge of ready is checked against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ready === 1'b1 && ready_d === 1'b0) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_ready: ready rose with sumFinal=%h, no result expected", sumFinal);
            end else begin
               e = sb.pop_front();
               vectors++;
               if (sumFinal !== e.sum) begin
                  miscompares++;
                  $display("FAIL sumFinal: got %h expected %h", sumFinal, e.sum);
               end
               vectors++;
               if (cyc != e.cyc) begin
                  miscompares++;
                  $display("FAIL ready_latency: ready at cycle %0d expected %0d", cyc, e.cyc);
               end
               if (e.chk_cout) begin
                  vectors++;
                  if (cout !== e.cout) begin
                     miscompares++;
                     $display("FAIL cout: got %b expected %b (sum %h)", cout, e.cout, e.sum);
                  end
               end
            end
         end
         ready_d = ready;
      end
   end

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic pm,
                      input logic [31:0] es, input logic ec, input logic chk, input int stall);
      exp_t e;
      @(negedge clk);
      A = a; B = b; PlusOrMinus = pm; cin = 1'b0; load = 1'b1;
      @(negedge clk);
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_clear: ready=%b expected 0 while load high", ready);
      end
      load = 1'b0;
      e.sum = es; e.cout = ec; e.chk_cout = chk; e.cyc = cyc + 3 + stall;
      sb.push_back(e);
      if (stall > 0) begin
         @(negedge clk);
         en = 1'b0;
         repeat (stall) @(negedge clk);
         en = 1'b1;
      end
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL timeout: ready never rose for %h op %h, expected %h", a, b, es);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic reset_mid_align();
      @(negedge clk);
      A = 32'h40A0_0000; B = 32'h4000_0000; PlusOrMinus = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (sumFinal !== 32'd0 || cout !== 1'b0 || ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_align: sumFinal=%h cout=%b ready=%b expected all 0", sumFinal, cout, ready);
      end
      load = 1'b1;
      rst  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; load = 1'b1; PlusOrMinus = 1'b0; cin = 1'b0;
      A = '0; B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (sumFinal !== 32'd0) begin miscompares++; $display("FAIL reset_sum: got %h expected 00000000", sumFinal); end
      vectors++;
      if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b expected 0", cout); end
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready); end
      rst = 1'b0;

      //    A             B             pm    expected      cout  chk   stall
      run(32'h40D80000, 32'h40400000, 1'b0, 32'h411C0000, 1'b0, 1'b0, 0);
      run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b1, 1'b1, 0);
      run(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b1, 1'b1, 0);
      reset_mid_align();
      run(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b1, 0);
      run(32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 0);
      run(32'h40000000, 32'h40A00000, 1'b0, 32'h40E00000, 1'b0, 1'b1, 0);
      run(32'h40A00000, 32'hC0000000, 1'b0, 32'h40400000, 1'b0, 1'b1, 0);
      run(32'h40000000, 32'hC0A00000, 1'b0, 32'hC0400000, 1'b0, 1'b1, 0);
      run(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 1'b0, 1'b1, 0);
      run(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b1, 0);
      run(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 0);
      run(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 0);
      run(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 0);
      run(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b1, 0);
      run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b0, 0);
      run(32'h40A00000, 32'h40000000, 1'b0, 32'h40E00000, 1'b0, 1'b1, 3);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
